// File: rtl/sram_responder_pkg.sv
// sram_responder_pkg: shared widths and default sizing for the SRAM responder
package sram_responder_pkg;
  localparam int DATA_W     = 32;
  localparam int LANES      = DATA_W / 8;
  localparam int DEF_ADDR_W = 14;
  localparam int DEF_CNT_W  = 16;
endpackage

// File: rtl/sram_responder_if.sv
// sram_responder_if: SRAM request/response bus between a requester and the responder
interface sram_responder_if;
  import sram_responder_pkg::*;
  logic              sram_en;
  logic [LANES-1:0]  sram_we;
  logic [31:0]       sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  modport master (output sram_en, sram_we, sram_addr, sram_wdata, input sram_rdata);
  modport slave  (input sram_en, sram_we, sram_addr, sram_wdata, output sram_rdata);
endinterface

// File: rtl/sram_responder_sat_counter.sv
// sat_counter: saturating up-counter with asynchronous active-low clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  // count up on request, sticking at all-ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (inc_i && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/sram_responder.sv
// sram_responder: single-port byte-writable SRAM with write-first read data, access counters and range check
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  sram_responder_if.slave  bus,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt,
  output logic             oor_err
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic              in_rng, rd, wr, oor;
  logic [DATA_W-1:0] merged, rdata_d, rdata_q;
  logic              oor_d, oor_q;
  logic              unused_addr_lsb;
  assign idx             = bus.sram_addr[ADDR_W+1:2];
  assign in_rng          = bus.sram_addr[31:ADDR_W+2] == '0;
  assign rd              = bus.sram_en && in_rng && bus.sram_we == '0;
  assign wr              = bus.sram_en && in_rng && bus.sram_we != '0;
  assign oor             = bus.sram_en && !in_rng;
  assign unused_addr_lsb = &{1'b0, bus.sram_addr[1:0]};
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign merged[8*i+:8] = bus.sram_we[i] ? bus.sram_wdata[8*i+:8] : mem[idx][8*i+:8];
  end
  // next read data: zero on out-of-range, merged word on access, hold when idle
  always_comb begin
    rdata_d = oor ? '0 : bus.sram_en ? merged : rdata_q;
    oor_d   = oor_q || oor;
  end
  // byte-lane writes into the array; a request during reset is discarded
  always_ff @(posedge clk)
    for (int i = 0; i < LANES; i++)
      if (resetn && wr && bus.sram_we[i]) mem[idx][8*i+:8] <= bus.sram_wdata[8*i+:8];
  // registered read data and sticky range error
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rdata_q <= '0;
      oor_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      oor_q   <= oor_d;
    end
  sat_counter #(.W(CNT_W)) u_rd_cnt (.clk(clk), .rst_n(resetn), .inc_i(rd), .cnt_o(rd_cnt));
  sat_counter #(.W(CNT_W)) u_wr_cnt (.clk(clk), .rst_n(resetn), .inc_i(wr), .cnt_o(wr_cnt));
  assign bus.sram_rdata = rdata_q;
  assign oor_err        = oor_q;
endmodule
